fpu_cmd_issuer: RTL

FPU_CMD_ISSUER -- requirements
Module: fpu_cmd_issuer

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_cmd_fifo.sv | 68 ++++++
 rtl/fpu_cmd_issuer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU command issuer.
//   state_e : issuer FSM states
//   Sel*    : 2-bit FPU operation codes
//   cmd_t   : one queued command record {a, b, sel, round}
package fpu_pkg;

   localparam int unsigned CmdW = 67;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StHold
   } state_e;

   localparam logic [1:0] SelAdd = 2'b00;
   localparam logic [1:0] SelSub = 2'b01;
   localparam logic [1:0] SelMul = 2'b10;
   localparam logic [1:0] SelDiv = 2'b11;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  sel;
      logic        round;
   } cmd_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO for the FPU issuer: DEPTH entries of cmd_t, wrap-around pointers.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write one entry (accepted when not full, or when full with a pop)
//   pop_i/rdata_o : remove the head entry; rdata_o shows the head
//   full_o, empty_o, count_o : occupancy status
module fpu_cmd_fifo
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  cmd_t                         wdata_i,
   input  logic                         pop_i,
   output cmd_t                         rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   cmd_t            mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            avail_q;
   logic            do_push, do_pop;

   assign do_pop  = pop_i & (count_q != '0);
   assign do_push = push_i & ((count_q != CntW'(DEPTH)) | do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         avail_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
         // Head is offered one cycle after it lands, so a freshly written entry is
         // never read on the same edge it is stored.
         avail_q <= (count_q != '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0) | ~avail_q;
   assign count_o = count_q;

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Queues FPU commands and issues them one at a time to a fixed-latency FPU.
//   clk, reset                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_* : command intake (a, b, sel, round)
//   fpu_A/B/sel/round, fpu_start : operand/start port to the FPU
//   fpu_Y, fpu_over_flow, fpu_error : FPU result, sampled LAT cycles after start
//   rsp_valid/rsp_ready, rsp_* : captured result with echoed opcode
//   busy                       : FSM not idle or commands still queued
module fpu_cmd_issuer
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LAT   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [1:0]  cmd_sel,
   input  logic        cmd_round,
   output logic [31:0] fpu_A,
   output logic [31:0] fpu_B,
   output logic [1:0]  fpu_sel,
   output logic        fpu_round,
   output logic        fpu_start,
   input  logic [31:0] fpu_Y,
   input  logic        fpu_over_flow,
   input  logic        fpu_error,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_y,
   output logic        rsp_over_flow,
   output logic        rsp_error,
   output logic [1:0]  rsp_sel,
   output logic        busy
);

   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam int unsigned WaitW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(LAT - 1);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q;
   cmd_t             push_cmd, head_cmd;
   logic             fifo_full, fifo_empty, fifo_push, fifo_pop, capture;
   logic [CntW-1:0]  fifo_count;
   logic [31:0]      fpu_a_q, fpu_b_q, rsp_y_q;
   logic [1:0]       fpu_sel_q, rsp_sel_q;
   logic             fpu_round_q, rsp_ovf_q, rsp_err_q;

   assign push_cmd  = '{a: cmd_a, b: cmd_b, sel: cmd_sel, round: cmd_round};
   assign cmd_ready = ~fifo_full;
   assign fifo_push = cmd_valid & cmd_ready;

   fpu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (fifo_push),
      .wdata_i (push_cmd),
      .pop_i   (fifo_pop),
      .rdata_o (head_cmd),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!fifo_empty) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (wait_cnt_q == WaitLast) state_d = StHold;
         StHold:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      fpu_start = (state_q == StIssue);
      rsp_valid = (state_q == StHold);
      fifo_pop  = (state_q == StIdle) & ~fifo_empty;
      capture   = (state_q == StWait) & (wait_cnt_q == WaitLast);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_q  <= '0;
         fpu_a_q     <= '0;
         fpu_b_q     <= '0;
         fpu_sel_q   <= '0;
         fpu_round_q <= 1'b0;
         rsp_y_q     <= '0;
         rsp_ovf_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_sel_q   <= '0;
      end else begin
         if (state_q == StIssue)     wait_cnt_q <= '0;
         else if (state_q == StWait) wait_cnt_q <= wait_cnt_q + WaitW'(1);
         // Operands stay on the FPU port until the next pop.
         if (fifo_pop) begin
            fpu_a_q     <= head_cmd.a;
            fpu_b_q     <= head_cmd.b;
            fpu_sel_q   <= head_cmd.sel;
            fpu_round_q <= head_cmd.round;
         end
         if (capture) begin
            rsp_y_q   <= fpu_Y;
            rsp_ovf_q <= fpu_over_flow;
            rsp_err_q <= fpu_error;
            rsp_sel_q <= fpu_sel_q;
         end
      end
   end

   assign fpu_A         = fpu_a_q;
   assign fpu_B         = fpu_b_q;
   assign fpu_sel       = fpu_sel_q;
   assign fpu_round     = fpu_round_q;
   assign rsp_y         = rsp_y_q;
   assign rsp_over_flow = rsp_ovf_q;
   assign rsp_error     = rsp_err_q;
   assign rsp_sel       = rsp_sel_q;
   assign busy          = (state_q != StIdle) | (fifo_count != '0);

endmodule
